sultans_round_accumulator: RTL and testbench

//   Downstream consumer of the sultans_of_swing stage: accepts its Ao/Bo/ANDo

---
 rtl/sultans_round_accumulator.sv | 142 ++++++++++++++
 tb/tb_sultans_round_accumulator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sultans_round_accumulator.sv
// sultans_round_accumulator
// Compression-accumulate stage of the mini hash datapath. Folds ROUNDS beats
// of (Ao, Bo, ANDo) nibbles from the sultans_of_swing stage into a running
// state word, then presents a feed-forward digest (state + IV) downstream.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid && ready are both high. The producer holds its payload stable
// while valid is high and ready is low. in_ready depends only on the FSM
// state and never on in_valid. out_valid and digest are registered and do not
// depend on out_ready.

module sultans_round_accumulator #(
    parameter int               WIDTH  = 4,
    parameter int               ROUNDS = 8,
    parameter logic [WIDTH-1:0] IV     = 4'h6
) (
    input  logic             clk,
    input  logic             reset,      // async, active-low
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] and_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] digest,
    output logic             busy,
    output logic [7:0]       round_cnt,
    output logic [1:0]       state_dbg   // FSM state, for checkers and debug
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Count value held while the final beat of a job is being accepted.
    localparam logic [7:0] LAST_CNT = 8'(ROUNDS - 1);

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [WIDTH-1:0] digest_q,    digest_d;
    logic [7:0]       round_cnt_q, round_cnt_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] a_rotl;
    logic [WIDTH-1:0] next_acc;
    logic             beat_fire;
    logic             out_fire;
    logic             last_beat;

    // Round function: acc + rotl1(a) + b + and, wrapping at WIDTH bits.
    always_comb begin
        a_rotl   = {a_in[WIDTH-2:0], a_in[WIDTH-1]};
        next_acc = acc_q + a_rotl + b_in + and_in;
    end

    // Port-level strobes derived from the registered state.
    always_comb begin
        in_ready  = (state_q == ST_RUN);
        busy      = (state_q != ST_IDLE);
        beat_fire = in_valid && in_ready;
        out_fire  = out_valid_q && out_ready;
        last_beat = (round_cnt_q == LAST_CNT);
    end

    // Next-state and datapath update; every register holds unless told otherwise.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        digest_d    = digest_q;
        round_cnt_d = round_cnt_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                // in_ready is low here, so a beat presented alongside start
                // is not consumed.
                if (start) begin
                    acc_d       = IV;
                    round_cnt_d = 8'd0;
                    state_d     = ST_RUN;
                end
            end

            ST_RUN: begin
                // start is ignored while a job is in flight; in_valid low is a stall.
                if (beat_fire) begin
                    acc_d       = next_acc;
                    round_cnt_d = round_cnt_q + 8'd1;
                    if (last_beat) begin
                        digest_d    = next_acc + IV;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // Digest held until taken; a start on the handshake cycle
                // is dropped, so the next job needs start in a later IDLE cycle.
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            digest_q    <= '0;
            round_cnt_q <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            digest_q    <= digest_d;
            round_cnt_q <= round_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Registered outputs driven straight from the flops.
    always_comb begin
        out_valid = out_valid_q;
        digest    = digest_q;
        round_cnt = round_cnt_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_sultans_round_accumulator.sv
// Testbench for sultans_round_accumulator (WIDTH=4, ROUNDS=8, IV=4'h6).
// Stimulus pushes hand-computed digests into exp_q; the monitor pops one on
// every output handshake and compares.

module tb_sultans_round_accumulator;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [3:0] and_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] digest;
    logic       busy;
    logic [7:0] round_cnt;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    sultans_round_accumulator #(
        .WIDTH (4),
        .ROUNDS(8),
        .IV    (4'h6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .and_in   (and_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .digest   (digest),
        .busy     (busy),
        .round_cnt(round_cnt),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // Handshake completes on the next rising edge; inputs are stable by now.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL digest_unexpected actual=%0h required=none", digest);
            end else begin
                check("digest", {28'd0, digest}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic ok;
        ok       = 1'b0;
        a_in     = a;
        b_in     = b;
        and_in   = c;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok = in_ready;
            next_cycle();
            if (ok) break;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_accept actual=not_ready required=accepted");
        end
        in_valid = 1'b0;
        a_in     = 4'd0;
        b_in     = 4'd0;
        and_in   = 4'd0;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL wait_idle actual=busy required=idle");
        end
        next_cycle();
    endtask

    task automatic zero_job();
        start_job();
        for (int i = 0; i < 8; i++) send_beat(4'd0, 4'd0, 4'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = 4'd0;
        b_in      = 4'd0;
        and_in    = 4'd0;

        // Test 1: reset held while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            start    = ~start;
            in_valid = ~in_valid;
            a_in     = 4'(i + 3);
            b_in     = 4'(i + 7);
            and_in   = 4'(i);
            @(negedge clk);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_in_ready",  {31'd0, in_ready},  32'd0);
            check("rst_digest",    {28'd0, digest},    32'd0);
            check("rst_busy",      {31'd0, busy},      32'd0);
            check("rst_round_cnt", {24'd0, round_cnt}, 32'd0);
            check("rst_state",     {30'd0, state_dbg}, 32'd0);
        end
        next_cycle();
        start    = 1'b0;
        in_valid = 1'b0;
        a_in     = 4'd0;
        b_in     = 4'd0;
        and_in   = 4'd0;
        reset    = 1'b1;
        next_cycle();

        // Test 2: all-zero job, acc stays 6, digest 6+6 = C.
        exp_q.push_back(4'hC);
        zero_job();
        check("t2_latency_valid", {31'd0, out_valid}, 32'd1);
        check("t2_round_cnt",     {24'd0, round_cnt}, 32'd8);
        wait_idle();

        // Test 3: rotl1(3)=6, 6+6+6+1 = 19 -> 3; digest 3+6 = 9.
        exp_q.push_back(4'h9);
        start_job();
        send_beat(4'd3, 4'd6, 4'd1);
        for (int i = 0; i < 7; i++) send_beat(4'd0, 4'd0, 4'd0);
        check("t3_latency_valid", {31'd0, out_valid}, 32'd1);
        wait_idle();

        // Test 4: stalls between beats and 5 cycles of backpressure.
        exp_q.push_back(4'h9);
        out_ready = 1'b0;
        start_job();
        send_beat(4'd3, 4'd6, 4'd1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("t4_stall_cnt", {24'd0, round_cnt}, 32'(i + 1));
            next_cycle();
            send_beat(4'd0, 4'd0, 4'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid",  {31'd0, out_valid}, 32'd1);
            check("t4_hold_digest", {28'd0, digest},    32'h9);
            check("t4_hold_ready",  {31'd0, in_ready},  32'd0);
            next_cycle();
        end
        out_ready = 1'b1;
        next_cycle();
        check("t4_idle_busy",   {31'd0, busy},      32'd0);
        check("t4_idle_valid",  {31'd0, out_valid}, 32'd0);
        check("t4_digest_held", {28'd0, digest},    32'h9);

        // Test 5: reset mid-RUN after 3 beats, then a clean zero job.
        start_job();
        for (int i = 0; i < 3; i++) send_beat(4'd5, 4'd2, 4'd7);
        check("t5_cnt_before", {24'd0, round_cnt}, 32'd3);
        reset = 1'b0;
        #1;
        check("t5_busy",      {31'd0, busy},      32'd0);
        check("t5_round_cnt", {24'd0, round_cnt}, 32'd0);
        check("t5_in_ready",  {31'd0, in_ready},  32'd0);
        check("t5_digest",    {28'd0, digest},    32'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        exp_q.push_back(4'hC);
        zero_job();
        wait_idle();

        // Test 6: protocol corners.
        exp_q.push_back(4'hC);
        start    = 1'b1;
        in_valid = 1'b1;
        a_in     = 4'd5;
        b_in     = 4'd5;
        and_in   = 4'd5;
        next_cycle();
        start    = 1'b0;
        in_valid = 1'b0;
        a_in     = 4'd0;
        b_in     = 4'd0;
        and_in   = 4'd0;
        @(negedge clk);
        check("t6_no_beat_cnt", {24'd0, round_cnt}, 32'd0);
        check("t6_run_busy",    {31'd0, busy},      32'd1);
        check("t6_run_ready",   {31'd0, in_ready},  32'd1);
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check("t6_start_in_run_cnt",   {24'd0, round_cnt}, 32'd0);
        check("t6_start_in_run_state", {30'd0, state_dbg}, 32'd1);
        next_cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(4'd0, 4'd0, 4'd0);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check("t6_start_in_done_state", {30'd0, state_dbg}, 32'd2);
        check("t6_start_in_done_valid", {31'd0, out_valid}, 32'd1);
        check("t6_done_round_cnt",      {24'd0, round_cnt}, 32'd8);
        next_cycle();
        out_ready = 1'b1;
        start     = 1'b1;
        next_cycle();
        start = 1'b0;
        check("t6_handshake_start_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        check("t6_still_idle", {31'd0, busy}, 32'd0);
        check("t6_idle_cnt",   {24'd0, round_cnt}, 32'd8);

        // Every pushed digest must have been delivered.
        next_cycle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
